// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding, common to the TX and RX paths.
package uart_pkg;

   localparam logic [12:0] DIV_9600   = 13'd325;
   localparam logic [12:0] DIV_19200  = 13'd162;
   localparam int          DATA_BITS  = 8;
   localparam int          OVERSAMPLE = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/uart_rx_tick.sv
// 16x oversampling tick generator; divider select is captured at the start edge
// so a baud change mid-frame never disturbs the frame being received.
module uart_rx_tick #(
   parameter logic [12:0] DIV_9600  = uart_pkg::DIV_9600,
   parameter logic [12:0] DIV_19200 = uart_pkg::DIV_19200
) (
   input  logic clk,
   input  logic rst,
   input  logic sw,
   input  logic run,
   input  logic start,
   output logic tick
);

   logic [12:0] cnt;
   logic [12:0] div;

   assign tick = run && (cnt >= div);

   // cnt sits at 0 while not running, which phase-aligns ticks to the start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= 13'd0;
         div <= DIV_9600;
      end else begin
         if (start) div <= sw ? DIV_19200 : DIV_9600;
         if (!run)            cnt <= 13'd0;
         else if (cnt >= div) cnt <= 13'd0;
         else                 cnt <= cnt + 13'd1;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchroniser, start-bit qualification, centre sampling and
// one-cycle rx_valid / frame_err strobes.
module uart_rx #(
   parameter logic [12:0] DIV_9600  = uart_pkg::DIV_9600,
   parameter logic [12:0] DIV_19200 = uart_pkg::DIV_19200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sw,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       rx_busy
);

   import uart_pkg::*;

   localparam logic [3:0] S_MID  = 4'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);
   localparam logic [2:0] B_LAST = 3'(DATA_BITS - 1);

   rx_state_t  state, state_nxt;
   logic       sync1, sync2, sync3;
   logic       fall;
   logic       tick;
   logic       run;
   logic       start_edge;
   logic       mid_start;
   logic       bit_end;
   logic [3:0] s_cnt;
   logic [2:0] b_cnt;
   logic [7:0] sh;

   // Resetting the synchroniser to 1 (idle line) avoids a false start edge after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         sync3 <= 1'b1;
      end else begin
         sync1 <= rxd;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign fall       = sync3 & ~sync2;
   assign run        = (state != IDLE);
   assign start_edge = (state == IDLE) && fall;
   assign mid_start  = tick && (s_cnt == S_MID);
   assign bit_end    = tick && (s_cnt == S_LAST);
   assign rx_busy    = run;

   uart_rx_tick #(
      .DIV_9600  (DIV_9600),
      .DIV_19200 (DIV_19200)
   ) u_tick (
      .clk   (clk),
      .rst   (rst),
      .sw    (sw),
      .run   (run),
      .start (start_edge),
      .tick  (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (fall)      state_nxt = START;
         START:   if (mid_start) state_nxt = sync2 ? IDLE : DATA;
         DATA:    if (bit_end && (b_cnt == B_LAST)) state_nxt = STOP;
         STOP:    if (bit_end)   state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_cnt     <= 4'd0;
         b_cnt     <= 3'd0;
         sh        <= 8'h00;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_valid  <= (state == STOP) && bit_end && sync2;
         frame_err <= (state == STOP) && bit_end && !sync2;
         case (state)
            IDLE: begin
               s_cnt <= 4'd0;
               b_cnt <= 3'd0;
            end
            START: begin
               // Restart the tick phase so each data bit is sampled 16 ticks on.
               if (mid_start && !sync2) begin
                  s_cnt <= 4'd0;
                  b_cnt <= 3'd0;
               end else if (tick) begin
                  s_cnt <= s_cnt + 4'd1;
               end
            end
            DATA: begin
               if (tick) s_cnt <= s_cnt + 4'd1;
               if (bit_end) begin
                  sh    <= {sync2, sh[7:1]};
                  b_cnt <= b_cnt + 3'd1;
               end
            end
            STOP: begin
               if (tick) s_cnt <= s_cnt + 4'd1;
               if (bit_end && sync2) rx_data <= sh;
            end
            default: s_cnt <= 4'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus randomized frames checked against a
// frame-level model (queue of expected events, byte value and latency window).
module tb_uart_rx;

   localparam logic [12:0] SIM_DIV_9600  = 13'd7;
   localparam logic [12:0] SIM_DIV_19200 = 13'd3;
   localparam int BIT_SLOW = 16 * (SIM_DIV_9600 + 1);
   localparam int BIT_FAST = 16 * (SIM_DIV_19200 + 1);

   logic       clk = 1'b0;
   logic       rst;
   logic       sw;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       rx_busy;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // exp_q entry: bit 8 = frame error expected, bits 7:0 = byte
   logic [8:0] exp_q[$];
   int         exp_t_q[$];
   int         exp_b_q[$];
   logic [7:0] last_good;
   logic       prev_evt;

   uart_rx #(
      .DIV_9600  (SIM_DIV_9600),
      .DIV_19200 (SIM_DIV_19200)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sw        (sw),
      .rxd       (rxd),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .rx_busy   (rx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_frame(input logic [7:0] data, input logic stop, input int bit_clks);
      rxd = 1'b0;
      idle(bit_clks);
      for (int i = 0; i < 8; i++) begin
         rxd = data[i];
         idle(bit_clks);
      end
      rxd = stop;
      idle(bit_clks);
   endtask

   task automatic send_byte(input logic [7:0] data, input logic stop, input int bit_clks);
      exp_q.push_back({~stop, data});
      exp_t_q.push_back(cyc);
      exp_b_q.push_back(bit_clks);
      drive_frame(data, stop, bit_clks);
   endtask

   // Monitor: every strobe must match the head of the expected queue.
   logic [8:0] m_e;
   int         m_t;
   int         m_b;
   int         m_lat;
   always @(negedge clk) begin
      if (rst) begin
         prev_evt = 1'b0;
      end else begin
         if (rx_valid || frame_err) begin
            check("valid_err_excl", {31'd0, rx_valid & frame_err}, 32'd0);
            check("pulse_width", {31'd0, prev_evt}, 32'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_event", 32'd1, 32'd0);
            end else begin
               m_e = exp_q.pop_front();
               m_t = exp_t_q.pop_front();
               m_b = exp_b_q.pop_front();
               check("event_kind", {31'd0, frame_err}, {31'd0, m_e[8]});
               if (!m_e[8]) begin
                  check("rx_data", {24'd0, rx_data}, {24'd0, m_e[7:0]});
                  last_good = m_e[7:0];
               end else begin
                  check("rx_data_hold", {24'd0, rx_data}, {24'd0, last_good});
               end
               // 9.5 bit times after the start edge, plus a few cycles of synchroniser delay
               m_lat = cyc - m_t;
               check("latency_lo", {31'd0, m_lat >= (m_b * 19) / 2}, 32'd1);
               check("latency_hi", {31'd0, m_lat <= (m_b * 19) / 2 + 4}, 32'd1);
            end
         end
         prev_evt = rx_valid | frame_err;
      end
   end

   initial begin
      logic [7:0] rb;
      logic       rs;
      logic       rstop;
      int         wait_cnt;

      rst       = 1'b1;
      sw        = 1'b0;
      rxd       = 1'b1;
      last_good = 8'h00;
      prev_evt  = 1'b0;
      idle(3);
      check("reset_rx_data", {24'd0, rx_data}, 32'd0);
      check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("reset_frame_err", {31'd0, frame_err}, 32'd0);
      check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
      rst = 1'b0;
      idle(10);

      // single frame at the slow rate
      sw = 1'b0;
      send_byte(8'hA5, 1'b1, BIT_SLOW);
      idle(2 * BIT_SLOW);

      // back-to-back frames at the fast rate
      sw = 1'b1;
      send_byte(8'h3C, 1'b1, BIT_FAST);
      send_byte(8'hC3, 1'b1, BIT_FAST);
      idle(2 * BIT_FAST);

      // short low glitch of 5 ticks must be rejected
      sw  = 1'b0;
      rxd = 1'b0;
      idle(5 * (SIM_DIV_9600 + 1));
      rxd = 1'b1;
      check("glitch_busy_mid", {31'd0, rx_busy}, 32'd1);
      idle(BIT_SLOW);
      check("glitch_busy_end", {31'd0, rx_busy}, 32'd0);
      idle(BIT_SLOW);

      // bad stop bit, then a long break
      send_byte(8'h55, 1'b0, BIT_SLOW);
      idle(30 * BIT_SLOW);
      check("break_busy", {31'd0, rx_busy}, 32'd0);
      check("break_no_pending", exp_q.size(), 32'd0);
      rxd = 1'b1;
      idle(2 * BIT_SLOW);

      // reset during data bit 4
      fork
         drive_frame(8'hFF, 1'b1, BIT_SLOW);
         begin
            idle(5 * BIT_SLOW + BIT_SLOW / 2);
            check("pre_rst_busy", {31'd0, rx_busy}, 32'd1);
            rst = 1'b1;
            #1;
            check("mid_rst_rx_data", {24'd0, rx_data}, 32'd0);
            check("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
            check("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
            check("mid_rst_rx_busy", {31'd0, rx_busy}, 32'd0);
            last_good = 8'h00;
            idle(3);
            rst = 1'b0;
         end
      join
      idle(2 * BIT_SLOW);
      send_byte(8'h00, 1'b1, BIT_SLOW);
      idle(2 * BIT_SLOW);

      // sw toggled mid-frame: baud stays at the rate latched on the start edge
      sw = 1'b0;
      fork
         send_byte(8'h81, 1'b1, BIT_SLOW);
         begin
            idle(300);
            sw = 1'b1;
            idle(400);
            sw = 1'b0;
            idle(200);
            sw = 1'b1;
         end
      join
      sw = 1'b0;
      idle(2 * BIT_SLOW);

      // randomized frames: random byte, rate and occasional bad stop bit
      for (int n = 0; n < 12; n++) begin
         rb    = 8'($urandom_range(0, 255));
         rs    = 1'($urandom_range(0, 1));
         rstop = ($urandom_range(0, 4) != 0);
         sw    = rs;
         send_byte(rb, rstop, rs ? BIT_FAST : BIT_SLOW);
         rxd = 1'b1;
         idle($urandom_range(4, 2 * BIT_SLOW));
      end

      wait_cnt = 0;
      while (exp_q.size() != 0 && wait_cnt < 4000) begin
         idle(1);
         wait_cnt++;
      end
      check("drain", exp_q.size(), 32'd0);
      check("final_busy", {31'd0, rx_busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
